// File: rtl/scan_reader.sv
// Scans a ROWS x COLS RAM in row-major order and streams each word out through a
// 2-entry skid FIFO with valid/ready handshaking, tagging the final word with m_last.
module scan_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(ROWS)-1:0]  r_row,
  output logic [$clog2(COLS)-1:0]  r_col,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);

  typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

  state_e                state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic                  inflight_q, inflight_last_q;
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic                  fifo_last_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q, count_d;
  logic                  done_q, done_d;

  logic                  pop, issue, at_end, head_last;
  logic [2:0]            occ;

  assign m_valid   = (count_q != 2'd0);
  assign head_last = fifo_last_q[rd_ptr_q];
  assign m_data    = m_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_last    = m_valid & head_last;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign r_row     = row_q;
  assign r_col     = col_q;

  assign pop    = m_valid & m_ready;
  assign at_end = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
  // A word leaving the FIFO this edge frees its slot, which keeps one word per clock
  // under continuous ready while still capping buffered + in-flight at two.
  assign occ    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue  = (state_q == StScan) && (occ < 3'd2);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
    unique case (state_q)
      StIdle:  if (start) state_d = StScan;
      StScan:  if (issue && at_end) state_d = StDrain;
      StDrain: begin
        if (pop && head_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (issue) begin
      if (col_q == CW'(COLS - 1)) begin
        col_d = '0;
        row_d = at_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      row_q           <= '0;
      col_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_last_q[0]  <= 1'b0;
      fifo_last_q[1]  <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      col_q           <= col_d;
      inflight_q      <= issue;
      inflight_last_q <= issue & at_end;
      count_q         <= count_d;
      done_q          <= done_d;
      if (inflight_q) begin
        fifo_data_q[wr_ptr_q] <= rd_data;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

endmodule
